// File: rtl/rgb_pwm_fader.sv
// rgb_pwm_fader: N-channel PWM LED driver with a run-time prescaler. Duty
// updates are taken only at PWM period boundaries. An optional fade mode
// ramps each active duty toward its pending value one LSB per fade step.
// period_tick is high in the clock after the boundary tick, which is the
// clock in which the internal counter first holds 0.
module rgb_pwm_fader #(
    parameter int CH         = 3,
    parameter int R          = 8,
    parameter int TIMER_BITS = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [TIMER_BITS-1:0] final_value,
    input  logic [CH*(R+1)-1:0]   target_duty,
    input  logic                  load,
    input  logic                  fade_en,
    input  logic [7:0]            fade_div,
    output logic [CH-1:0]         pwm_out,
    output logic                  period_tick,
    output logic                  busy
);

    localparam int            DW       = R + 1;
    localparam logic [R:0]    DUTY_MAX = {1'b1, {R{1'b0}}};
    localparam logic [R:0]    DUTY_ONE = (R+1)'(1);
    localparam logic [R-1:0]  CNT_LAST = {R{1'b1}};

    logic [TIMER_BITS-1:0]  presc_q, presc_d;
    logic [R-1:0]           cnt_q, cnt_d;
    logic [7:0]             fcnt_q, fcnt_d;
    logic                   restart_q, restart_d;
    logic [CH-1:0][R:0]     pend_q, pend_d;
    logic [CH-1:0][R:0]     act_q, act_d;
    logic [CH-1:0]          pwm_q, pwm_d;
    logic                   tick_q, busy_q, busy_d;
    logic                   tick, pb, fade_step;
    logic [R:0]             raw;

    // Prescaler and PWM counter: one tick per final_value+1 clocks, boundary on the wrap.
    always_comb begin
        // NOTE: always_comb uses blocking '=' so later lines see earlier results;
        // state registers below use '<=' so every flop samples pre-edge values.
        tick    = (presc_q == final_value);
        // A final_value lowered below the count lets the prescaler run on to
        // its natural overflow rather than being clamped.
        presc_d = tick ? '0 : presc_q + TIMER_BITS'(1);
        pb      = tick && (cnt_q == CNT_LAST);
        cnt_d   = tick ? cnt_q + R'(1) : cnt_q;
    end

    // Fade step scheduler: counts boundaries and restarts after fade_en was low.
    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        fade_step = 1'b0;
        fcnt_d    = fcnt_q;
        restart_d = restart_q;
        if (!fade_en) begin
            restart_d = 1'b1;
        end else if (pb) begin
            if (restart_q) begin
                // First boundary after fade_en rises only realigns the counter.
                fcnt_d    = '0;
                restart_d = 1'b0;
            end else if (fcnt_q == fade_div) begin
                fcnt_d    = '0;
                fade_step = 1'b1;
            end else begin
                fcnt_d = fcnt_q + 8'd1;
            end
        end
    end

    // Per-channel pending capture, boundary update of active duty, compare and busy.
    always_comb begin
        pend_d = pend_q;
        act_d  = act_q;
        pwm_d  = '0;
        busy_d = 1'b0;
        raw    = '0;
        for (int i = 0; i < CH; i++) begin
            if (load) begin
                raw       = target_duty[i*DW +: DW];
                pend_d[i] = (raw > DUTY_MAX) ? DUTY_MAX : raw;
            end
            // Boundary update reads pend_q, so a load in the boundary cycle
            // waits for the following boundary.
            if (pb) begin
                if (!fade_en) begin
                    act_d[i] = pend_q[i];
                end else if (fade_step) begin
                    if (act_q[i] < pend_q[i]) begin
                        act_d[i] = act_q[i] + DUTY_ONE;
                    end else if (act_q[i] > pend_q[i]) begin
                        act_d[i] = act_q[i] - DUTY_ONE;
                    end
                end
            end
            pwm_d[i] = ({1'b0, cnt_q} < act_q[i]);
            busy_d   = busy_d | (act_d[i] != pend_d[i]);
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the per-channel duty registers are a handful of flops, not a
            // RAM, so they are cleared with everything else; reset mid-period
            // therefore leaves no partial pulse behind.
            presc_q   <= '0;
            cnt_q     <= '0;
            fcnt_q    <= '0;
            restart_q <= 1'b0;
            pend_q    <= '0;
            act_q     <= '0;
            pwm_q     <= '0;
            tick_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            cnt_q     <= cnt_d;
            fcnt_q    <= fcnt_d;
            restart_q <= restart_d;
            pend_q    <= pend_d;
            act_q     <= act_d;
            pwm_q     <= pwm_d;
            tick_q    <= pb;
            busy_q    <= busy_d;
        end
    end

    assign pwm_out     = pwm_q;
    assign period_tick = tick_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_rgb_pwm_fader.sv
// Bench for rgb_pwm_fader: scenario tasks measure whole periods against the
// duty arithmetic, while a cycle model checks every output on every clock.
module tb_rgb_pwm_fader;

    localparam int CH     = 3;
    localparam int R      = 8;
    localparam int TW     = 8;
    localparam int DW     = R + 1;
    localparam int PERIOD = 1 << R;

    logic              clk = 1'b0;
    logic              reset;
    logic [TW-1:0]     final_value;
    logic [CH*DW-1:0]  target_duty;
    logic              load;
    logic              fade_en;
    logic [7:0]        fade_div;
    logic [CH-1:0]     pwm_out;
    logic              period_tick;
    logic              busy;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Reference model state (plain integers).
    int          m_presc = 0, m_cnt = 0, m_fcnt = 0;
    bit          m_off_seen = 0;
    int          m_pend[CH], m_act[CH];
    logic [CH-1:0] e_pwm = '0;
    logic        e_tick = 0, e_busy = 0;

    // Results of the last measured period.
    int   r_high[CH];
    int   r_len;
    logic r_busy_end, r_busy_prev;

    rgb_pwm_fader #(.CH(CH), .R(R), .TIMER_BITS(TW)) dut (
        .clk         (clk),
        .reset       (reset),
        .final_value (final_value),
        .target_duty (target_duty),
        .load        (load),
        .fade_en     (fade_en),
        .fade_div    (fade_div),
        .pwm_out     (pwm_out),
        .period_tick (period_tick),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [CH*DW-1:0] all_duty(input int v);
        logic [CH*DW-1:0] r;
        for (int i = 0; i < CH; i++) r[i*DW +: DW] = DW'(v);
        return r;
    endfunction

    // One clock of the behavioural model, using the inputs sampled at this edge.
    task automatic model_step();
        bit t, b;
        int v;
        if (reset) begin
            m_presc = 0; m_cnt = 0; m_fcnt = 0; m_off_seen = 0;
            for (int i = 0; i < CH; i++) begin m_pend[i] = 0; m_act[i] = 0; end
            e_pwm = '0; e_tick = 0; e_busy = 0;
            return;
        end
        t = (m_presc == int'(final_value));
        b = t && (m_cnt == PERIOD - 1);
        for (int i = 0; i < CH; i++) e_pwm[i] = (m_cnt < m_act[i]);
        e_tick = b;
        if (b) begin
            if (!fade_en) begin
                for (int i = 0; i < CH; i++) m_act[i] = m_pend[i];
            end else if (m_off_seen) begin
                m_fcnt = 0; m_off_seen = 0;
            end else if (m_fcnt == int'(fade_div)) begin
                m_fcnt = 0;
                for (int i = 0; i < CH; i++) begin
                    if (m_act[i] < m_pend[i]) m_act[i]++;
                    else if (m_act[i] > m_pend[i]) m_act[i]--;
                end
            end else begin
                m_fcnt++;
            end
        end
        if (!fade_en) m_off_seen = 1;
        m_presc = t ? 0 : (m_presc + 1) % (1 << TW);
        if (t) m_cnt = (m_cnt + 1) % PERIOD;
        if (load) begin
            for (int i = 0; i < CH; i++) begin
                v = int'(target_duty[i*DW +: DW]);
                m_pend[i] = (v > PERIOD) ? PERIOD : v;
            end
        end
        e_busy = 0;
        for (int i = 0; i < CH; i++) if (m_act[i] != m_pend[i]) e_busy = 1;
    endtask

    task automatic clock_cycle();
        @(posedge clk);
        model_step();
        cyc++;
        #1;
        vectors++;
        if ({pwm_out, period_tick, busy} !== {e_pwm, e_tick, e_busy}) begin
            miscompares++;
            $display("FAIL cycle_model @%0d: got pwm=%b tick=%b busy=%b, want pwm=%b tick=%b busy=%b",
                     cyc, pwm_out, period_tick, busy, e_pwm, e_tick, e_busy);
        end
    endtask

    task automatic do_load(input logic [CH*DW-1:0] d);
        target_duty = d;
        load = 1'b1;
        clock_cycle();
        load = 1'b0;
    endtask

    // Runs until the next period_tick; optional load on iteration load_at.
    task automatic measure_period(input int load_at, input int load_val);
        logic prev_busy;
        r_len = 0;
        foreach (r_high[i]) r_high[i] = 0;
        r_busy_prev = 1'b0;
        r_busy_end  = 1'b0;
        forever begin
            prev_busy = busy;
            if (r_len == load_at) begin
                target_duty = all_duty(load_val);
                load = 1'b1;
            end
            clock_cycle();
            load = 1'b0;
            r_len++;
            for (int i = 0; i < CH; i++) r_high[i] += int'(pwm_out[i]);
            if (period_tick === 1'b1) begin
                r_busy_prev = prev_busy;
                r_busy_end  = busy;
                break;
            end
            if (r_len >= 20000) begin
                vectors++;
                miscompares++;
                $display("FAIL period_timeout: got no period_tick in %0d clocks, want one", r_len);
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) clock_cycle();
        reset = 1'b0;
        do_load(all_duty(128));
        repeat (120) clock_cycle();
        reset = 1'b1;
        repeat (3) begin
            clock_cycle();
            vectors++;
            if ({pwm_out, period_tick, busy} !== {(CH+2){1'b0}}) begin
                miscompares++;
                $display("FAIL reset_outputs: got %b, want all zero", {pwm_out, period_tick, busy});
            end
        end
        reset = 1'b0;
        measure_period(-1, 0);
        vectors++;
        if (r_len !== PERIOD) begin
            miscompares++;
            $display("FAIL reset_restart_len: got %0d, want %0d", r_len, PERIOD);
        end
        for (int i = 0; i < CH; i++) begin
            vectors++;
            if (r_high[i] !== 0) begin
                miscompares++;
                $display("FAIL reset_cleared_duty ch%0d: got %0d high, want 0", i, r_high[i]);
            end
        end
        vectors++;
        if (r_busy_end !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_busy: got %b, want 0", r_busy_end);
        end
    endtask

    task automatic test_direct();
        int exp_h[CH];
        exp_h[0] = 0; exp_h[1] = 64; exp_h[2] = 256;
        do_load({DW'(256), DW'(64), DW'(0)});
        measure_period(-1, 0);
        repeat (2) begin
            measure_period(-1, 0);
            vectors++;
            if (r_len !== PERIOD) begin
                miscompares++;
                $display("FAIL direct_len: got %0d, want %0d", r_len, PERIOD);
            end
            for (int i = 0; i < CH; i++) begin
                vectors++;
                if (r_high[i] !== exp_h[i]) begin
                    miscompares++;
                    $display("FAIL direct_high ch%0d: got %0d, want %0d", i, r_high[i], exp_h[i]);
                end
            end
        end
    endtask

    task automatic test_prescaler();
        int fv, d;
        for (int k = 0; k < 3; k++) begin
            fv = (k == 0) ? 3 : int'($urandom_range(1, 5));
            d  = (k == 0) ? 10 : int'($urandom_range(0, 256));
            final_value = TW'(fv);
            do_load(all_duty(d));
            measure_period(-1, 0);
            measure_period(-1, 0);
            vectors++;
            if (r_len !== PERIOD * (fv + 1)) begin
                miscompares++;
                $display("FAIL presc_len fv=%0d: got %0d, want %0d", fv, r_len, PERIOD * (fv + 1));
            end
            for (int i = 0; i < CH; i++) begin
                vectors++;
                if (r_high[i] !== d * (fv + 1)) begin
                    miscompares++;
                    $display("FAIL presc_high fv=%0d ch%0d: got %0d, want %0d", fv, i, r_high[i], d * (fv + 1));
                end
            end
        end
        final_value = '0;
    endtask

    task automatic test_boundary();
        int load_at[5], load_v[5], exp_h[5];
        load_at = '{50, -1, 255, -1, -1};
        load_v  = '{200, 0, 30, 0, 0};
        exp_h   = '{100, 200, 200, 200, 30};
        do_load(all_duty(100));
        measure_period(-1, 0);
        for (int k = 0; k < 5; k++) begin
            measure_period(load_at[k], load_v[k]);
            for (int i = 0; i < CH; i++) begin
                vectors++;
                if (r_high[i] !== exp_h[k]) begin
                    miscompares++;
                    $display("FAIL boundary_high step%0d ch%0d: got %0d, want %0d", k, i, r_high[i], exp_h[k]);
                end
            end
        end
    endtask

    task automatic test_fade();
        int exp_h[18];
        bit exp_b[18];
        // Up ramp 0->4 (first boundary realigns the fade counter), then down 4->0.
        exp_h = '{0, 0, 0, 1, 1, 2, 2, 3, 3, 4, 4, 3, 3, 2, 2, 1, 1, 0};
        exp_b = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 1, 0, 0};
        do_load(all_duty(0));
        measure_period(-1, 0);
        fade_div = 8'd1;
        fade_en  = 1'b1;
        for (int k = 0; k < 18; k++) begin
            measure_period((k == 0 || k == 10) ? 0 : -1, (k == 0) ? 4 : 0);
            for (int i = 0; i < CH; i++) begin
                vectors++;
                if (r_high[i] !== exp_h[k]) begin
                    miscompares++;
                    $display("FAIL fade_high period%0d ch%0d: got %0d, want %0d", k, i, r_high[i], exp_h[k]);
                end
            end
            vectors++;
            if (r_busy_end !== logic'(exp_b[k])) begin
                miscompares++;
                $display("FAIL fade_busy period%0d: got %b, want %b", k, r_busy_end, exp_b[k]);
            end
            if (k == 8 || k == 16) begin
                vectors++;
                if (r_busy_prev !== 1'b1) begin
                    miscompares++;
                    $display("FAIL fade_busy_before_fall period%0d: got %b, want 1", k, r_busy_prev);
                end
            end
        end
    endtask

    task automatic test_saturation();
        int exp_h[5];
        exp_h = '{256, 256, 256, 255, 250};
        fade_en = 1'b0;
        do_load(all_duty(300));
        measure_period(-1, 0);
        fade_div = 8'd0;
        for (int k = 0; k < 5; k++) begin
            if (k == 1) fade_en = 1'b1;
            if (k == 4) begin
                // Abort the ramp mid-period; the next boundary jumps to pending.
                repeat (100) clock_cycle();
                fade_en = 1'b0;
                measure_period(-1, 0);
            end
            measure_period((k == 1) ? 0 : -1, 250);
            for (int i = 0; i < CH; i++) begin
                vectors++;
                if (r_high[i] !== exp_h[k]) begin
                    miscompares++;
                    $display("FAIL sat_abort_high step%0d ch%0d: got %0d, want %0d", k, i, r_high[i], exp_h[k]);
                end
            end
        end
        vectors++;
        if (r_busy_end !== 1'b0) begin
            miscompares++;
            $display("FAIL sat_abort_busy: got %b, want 0", r_busy_end);
        end
    endtask

    task automatic test_random();
        logic [CH*DW-1:0] d;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 39) == 0) begin
                for (int i = 0; i < CH; i++) d[i*DW +: DW] = DW'($urandom_range(0, 511));
                target_duty = d;
                load = 1'b1;
            end
            if ($urandom_range(0, 199) == 0) fade_en = ~fade_en;
            if ($urandom_range(0, 299) == 0) final_value = TW'($urandom_range(0, 3));
            if ($urandom_range(0, 299) == 0) fade_div = 8'($urandom_range(0, 2));
            if ($urandom_range(0, 999) == 0) reset = 1'b1;
            clock_cycle();
            load  = 1'b0;
            reset = 1'b0;
        end
    endtask

    initial begin
        reset       = 1'b1;
        final_value = '0;
        target_duty = '0;
        load        = 1'b0;
        fade_en     = 1'b0;
        fade_div    = '0;
        for (int i = 0; i < CH; i++) begin m_pend[i] = 0; m_act[i] = 0; end
        test_reset();
        test_direct();
        test_prescaler();
        test_boundary();
        test_fade();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rgb_pwm_fader.md
# rgb_pwm_fader

Parametrised N-channel PWM LED driver, the successor to the fixed three-channel RGB driver. It adds a run-time switching-frequency prescaler and glitch-free duty updates taken only at PWM period boundaries. An optional fade mode ramps each channel's duty toward its target one LSB at a time. It sits between the register/control logic and the LED pins and drives one PWM output per channel.

## Interface

- CH, 3, number of PWM channels
- R, 8, PWM resolution in bits; period = 2^R ticks; duty range 0..2^R (R+1 bits)
- TIMER_BITS, 8, prescaler width

- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- final_value  in  TIMER_BITS  prescaler terminal count; one PWM tick every final_value+1 clocks
- target_duty  in  CH*(R+1)  packed target duties; channel i at bits [i*(R+1) +: R+1]
- load  in  1  single-cycle strobe; captures target_duty into pending registers
- fade_en  in  1  0 = direct update at boundary, 1 = ramp by ±1 per fade step
- fade_div  in  8  fade step taken every fade_div+1 PWM periods
- pwm_out  out  CH  registered PWM outputs
- period_tick  out  1  one-cycle pulse at each PWM period start
- busy  out  1  high while any active duty differs from its pending duty

## Operation

- Prescaler: counts 0..final_value. Asserts internal tick in the cycle it equals final_value, then wraps to 0. final_value=0 gives a tick every clock. final_value is sampled live; lowering it below the current count wraps the prescaler at its TIMER_BITS overflow. No other correction is applied.
- PWM counter: R bits, advances on tick, wraps 2^R-1 -> 0. The tick causing that wrap is the period boundary (pb).
- pending[i]: on load, captures target_duty[i]. Values above 2^R saturate to 2^R. Load has no other effect.
- active[i] update at pb only:
  - fade_en=0: active <= pending.
  - fade_en=1: a fade counter (8 bits) counts pb events 0..fade_div. On the pb where it equals fade_div, it resets and each active[i] moves one step toward pending[i] (+1 or -1). Equal channels are unchanged.
- Clearing fade_en mid-ramp: the next pb jumps active to pending. The fade counter holds while fade_en=0 and resets to 0 on the next pb after fade_en rises.
- Compare: pwm_out[i] next = (counter < active[i]). active=0 gives a constant low output. active=2^R gives a constant high output.
- busy = OR over i of (active[i] != pending[i]), registered.

## Timing

- Reset (synchronous, clk edge with reset=1) clears prescaler, counter, fade counter, all pending and active, pwm_out=0, period_tick=0, busy=0. Reset mid-period aborts the period immediately. No partial pulse is emitted after reset is released.
- pwm_out is registered. It reflects the counter/active state of the previous clock, giving 1 clock of latency from the counter to the pin.
- period_tick is high for exactly the clock after the pb tick, aligned with the first output cycle of the new period.
- High time per period = active[i] * (final_value+1) clocks. Period = 2^R * (final_value+1) clocks.
- Duty change never truncates or extends a period in progress. The new active value takes effect at the first counter value 0 after pb.
- Load and pb in the same cycle: that pb uses the old pending. The newly loaded value is used at the following pb.
- busy rises 1 clock after a load that changes pending. It falls 1 clock after the pb where active reaches pending.
- Fade latency from active=a to pending=p: |p-a| * (fade_div+1) periods.

## Test plan

- Reset check: R=8, final_value=0, load all channels 128, then assert reset for 3 clocks mid-period. All outputs must be 0 during reset. Counter restarts from 0. pending=active=0, busy=0.
- Direct duty: R=8, final_value=0, fade_en=0, load {0, 64, 256}. After the next pb, each 256-clock period must show ch0 constantly low, ch1 high for 64 clocks, ch2 constantly high. period_tick must pulse every 256 clocks.
- Prescaler: final_value=3, duty 10. Period must be 1024 clocks with a high time of 40 clocks. final_value=195 gives a period of 50176 clocks.
- Boundary update: load 200 while counter=50 during duty 100. The current period keeps its 100-tick high time. The next period shows 200. Load coinciding with pb must be applied one period later.
- Fade: fade_en=1, fade_div=1, active 0 -> load 4. Duty must be 1, 2, 3, 4, each held for 2 periods. busy must fall 1 clock after the pb that reaches 4. A ramp down 4 -> 0 must mirror this.
- Saturation/abort: load 300 with R=8. pending must be 256. Clearing fade_en mid-ramp must jump to pending at the next pb.
